// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM: Moore control outputs registered from the
// next state, plus a retired-instruction counter.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_en,
  output logic [1:0]  pc_source,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    ALU_WB    = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    I_EXEC    = 4'd10,
    IDLE      = 4'd11,
    ILLEGAL   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t      state_q;
  state_t      nxt;
  logic [5:0]  op_q;
  logic [5:0]  nxt_op;
  logic        retire;

  always_comb begin
    nxt    = state_q;
    nxt_op = op_q;
    case (state_q)
      IDLE:     nxt = FETCH;
      FETCH:    if (mem_ready) nxt = DECODE;
      DECODE: begin
        nxt_op = opcode;
        case (opcode)
          OP_RTYPE:      nxt = R_EXEC;
          OP_J, OP_JAL:  nxt = JUMP;
          OP_BEQ:        nxt = BRANCH;
          OP_ADDI:       nxt = I_EXEC;
          OP_LW, OP_SW:  nxt = MEM_ADDR;
          default:       nxt = ILLEGAL;
        endcase
      end
      MEM_ADDR:  nxt = (op_q == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (mem_ready) nxt = MEM_WB;
      MEM_WRITE: if (mem_ready) nxt = FETCH;
      MEM_WB, ALU_WB, BRANCH, JUMP: nxt = FETCH;
      R_EXEC, I_EXEC: nxt = ALU_WB;
      ILLEGAL:   nxt = ILLEGAL;
      default:   nxt = ILLEGAL;
    endcase
  end

  assign retire = (nxt == FETCH) &&
                  (state_q inside {MEM_WB, MEM_WRITE, ALU_WB, BRANCH, JUMP});

  // Outputs are decoded from the state being entered so they are valid from the
  // first cycle of that state without a combinational decode after the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      instr_count <= '0;
      mem_req     <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      i_or_d      <= 1'b0;
      pc_source   <= '0;
      alu_src_a   <= 1'b0;
      alu_src_b   <= '0;
      alu_op      <= '0;
      reg_write   <= 1'b0;
      reg_dst     <= '0;
      mem_to_reg  <= '0;
      illegal     <= 1'b0;
    end else begin
      state_q <= nxt;
      op_q    <= nxt_op;
      if (retire) instr_count <= instr_count + 32'd1;

      mem_req    <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      i_or_d     <= 1'b0;
      pc_source  <= '0;
      alu_src_a  <= 1'b0;
      alu_src_b  <= '0;
      alu_op     <= '0;
      reg_write  <= 1'b0;
      reg_dst    <= '0;
      mem_to_reg <= '0;
      illegal    <= 1'b0;
      case (nxt)
        FETCH: begin
          mem_req   <= 1'b1;
          mem_read  <= 1'b1;
          alu_src_b <= 2'b01;
        end
        DECODE:   alu_src_b <= 2'b11;
        MEM_ADDR: begin
          alu_src_a <= 1'b1;
          alu_src_b <= 2'b10;
        end
        MEM_READ: begin
          mem_req  <= 1'b1;
          mem_read <= 1'b1;
          i_or_d   <= 1'b1;
        end
        MEM_WB: begin
          reg_write  <= 1'b1;
          mem_to_reg <= 2'b01;
        end
        MEM_WRITE: begin
          mem_req   <= 1'b1;
          mem_write <= 1'b1;
          i_or_d    <= 1'b1;
        end
        R_EXEC: begin
          alu_src_a <= 1'b1;
          alu_op    <= 2'b10;
        end
        I_EXEC: begin
          alu_src_a <= 1'b1;
          alu_src_b <= 2'b10;
        end
        ALU_WB: begin
          reg_write <= 1'b1;
          reg_dst   <= (nxt_op == OP_RTYPE) ? 2'b01 : 2'b00;
        end
        BRANCH: begin
          alu_src_a <= 1'b1;
          alu_op    <= 2'b01;
          pc_source <= 2'b01;
        end
        JUMP: begin
          pc_source <= 2'b10;
          if (nxt_op == OP_JAL) begin
            reg_write  <= 1'b1;
            reg_dst    <= 2'b10;
            mem_to_reg <= 2'b10;
          end
        end
        ILLEGAL: illegal <= 1'b1;
        default: ;
      endcase
    end
  end

  // ir_write and pc_en are qualified by same-cycle inputs, so they stay combinational.
  always_comb begin
    ir_write = (state_q == FETCH) && mem_ready;
    pc_en    = ((state_q == FETCH) && mem_ready) ||
               ((state_q == BRANCH) && zero) ||
               (state_q == JUMP);
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into its
// expected per-cycle state trace and control outputs, then compared cycle by cycle.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_read, mem_write, i_or_d, ir_write, pc_en;
  logic [1:0]  pc_source, alu_src_b, alu_op, reg_dst, mem_to_reg;
  logic        alu_src_a, reg_write, illegal;
  logic [3:0]  state;
  logic [31:0] instr_count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_count = '0;

  typedef struct { int st; bit rdy; } step_t;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MADDR = 2, S_MREAD = 3, S_MWB = 4,
                 S_MWRITE = 5, S_REXEC = 6, S_ALUWB = 7, S_BRANCH = 8, S_JUMP = 9,
                 S_IEXEC = 10, S_IDLE = 11, S_ILLEGAL = 15;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_en(pc_en), .pc_source(pc_source), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [18:0] ctrl;
  assign ctrl = {mem_req, mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source,
                 alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Control outputs a state must present, written from the state table.
  function automatic logic [18:0] exp_ctrl(input int st, input logic [5:0] op,
                                           input bit rdy, input bit z);
    logic req = 0, rd = 0, wr = 0, iod = 0, irw = 0, pce = 0, srca = 0, rw = 0, ill = 0;
    logic [1:0] pcs = 0, srcb = 0, aop = 0, rdst = 0, m2r = 0;
    case (st)
      S_FETCH:   begin req = 1; rd = 1; srcb = 2'b01; irw = rdy; pce = rdy; end
      S_DECODE:  srcb = 2'b11;
      S_MADDR:   begin srca = 1; srcb = 2'b10; end
      S_MREAD:   begin req = 1; rd = 1; iod = 1; end
      S_MWB:     begin rw = 1; m2r = 2'b01; end
      S_MWRITE:  begin req = 1; wr = 1; iod = 1; end
      S_REXEC:   begin srca = 1; aop = 2'b10; end
      S_ALUWB:   begin rw = 1; rdst = (op == 6'h00) ? 2'b01 : 2'b00; end
      S_BRANCH:  begin srca = 1; aop = 2'b01; pcs = 2'b01; pce = z; end
      S_JUMP: begin
        pce = 1; pcs = 2'b10;
        if (op == 6'h03) begin rw = 1; rdst = 2'b10; m2r = 2'b10; end
      end
      S_IEXEC:   begin srca = 1; srcb = 2'b10; end
      S_ILLEGAL: ill = 1;
      default: ;
    endcase
    return {req, rd, wr, iod, irw, pce, pcs, srca, srcb, aop, rw, rdst, m2r, ill};
  endfunction

  // Runs one instruction: wf/wm are fetch and data-memory wait cycles, zmode<0
  // randomizes zero, stop>=0 abandons the trace after that many cycles.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm,
                           input int zmode, input int stop);
    step_t q[$];
    bit    finished = 1;
    for (int i = 0; i < wf; i++) q.push_back('{S_FETCH, 1'b0});
    q.push_back('{S_FETCH, 1'b1});
    q.push_back('{S_DECODE, 1'($urandom)});
    case (op)
      6'h00: begin q.push_back('{S_REXEC, 1'($urandom)}); q.push_back('{S_ALUWB, 1'($urandom)}); end
      6'h08: begin q.push_back('{S_IEXEC, 1'($urandom)}); q.push_back('{S_ALUWB, 1'($urandom)}); end
      6'h04: q.push_back('{S_BRANCH, 1'($urandom)});
      6'h02, 6'h03: q.push_back('{S_JUMP, 1'($urandom)});
      6'h23, 6'h2B: begin
        q.push_back('{S_MADDR, 1'($urandom)});
        for (int i = 0; i < wm; i++) q.push_back('{(op == 6'h23) ? S_MREAD : S_MWRITE, 1'b0});
        q.push_back('{(op == 6'h23) ? S_MREAD : S_MWRITE, 1'b1});
        if (op == 6'h23) q.push_back('{S_MWB, 1'($urandom)});
      end
      default: begin
        finished = 0;
        for (int i = 0; i < 20; i++) q.push_back('{S_ILLEGAL, 1'($urandom)});
      end
    endcase
    if (stop >= 0) begin
      finished = 0;
      while (q.size() > stop) void'(q.pop_back());
    end
    foreach (q[i]) begin
      bit z;
      @(negedge clk);
      z = (zmode < 0) ? 1'($urandom) : zmode[0];
      mem_ready = q[i].rdy;
      zero      = z;
      opcode    = (q[i].st == S_DECODE) ? op : 6'($urandom);
      #1;
      check("state", 32'(state), 32'(q[i].st));
      check("ctrl", 32'(ctrl), 32'(exp_ctrl(q[i].st, op, q[i].rdy, z)));
      check("count", instr_count, exp_count);
    end
    if (finished) begin
      exp_count = exp_count + 32'd1;
      @(negedge clk);
      mem_ready = 1'b0;
      opcode    = 6'($urandom);
      #1;
      check("retire_state", 32'(state), S_FETCH);
      check("retire_ctrl", 32'(ctrl), 32'(exp_ctrl(S_FETCH, op, 1'b0, zero)));
      check("retire_count", instr_count, exp_count);
    end
  endtask

  // Asserts reset between clock edges, checks it takes effect at once, then releases.
  task automatic apply_reset(input bit preload);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_state", 32'(state), S_IDLE);
    check("rst_ctrl", 32'(ctrl), 32'(exp_ctrl(S_IDLE, 6'h00, mem_ready, zero)));
    check("rst_count", instr_count, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_count = '0;
    if (preload) begin
      force dut.instr_count = 32'hFFFF_FFFF;
      #1 release dut.instr_count;
      exp_count = 32'hFFFF_FFFF;
    end else begin
      #1;
    end
    check("idle_state", 32'(state), S_IDLE);
    check("idle_count", instr_count, exp_count);
  endtask

  initial begin
    logic [5:0] ops [7] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h23, 6'h2B};

    apply_reset(0);
    run_instr(6'h00, 0, 0, -1, -1);
    run_instr(6'h23, 0, 3, -1, -1);
    run_instr(6'h04, 0, 0, 1, -1);
    run_instr(6'h04, 1, 0, 0, -1);
    run_instr(6'h03, 0, 0, -1, -1);
    run_instr(6'h2B, 2, 1, -1, -1);

    for (int n = 0; n < 120; n++)
      run_instr(ops[$urandom_range(0, 6)], int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), -1, -1);

    run_instr(6'h3F, 0, 0, -1, -1);
    apply_reset(0);
    run_instr(6'h2B, 0, 6, -1, 5);
    apply_reset(1);
    run_instr(6'h08, 1, 0, -1, -1);
    run_instr(6'h02, 0, 0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete, errors %0d", errors);
    $fatal(1, "timeout");
  end

endmodule
